// File: rtl/mem_stage.sv
// MEM pipeline stage: registers the EX bus, aligns load data, holds SRAM data across WB stalls.
// Optional MS_FWD_EN drives forwarding data/we on ms_to_ds_bus; otherwise only stall bits are live.
module mem_stage #(
  parameter int ES_MS_W = 172,
  parameter int MS_WS_W = 167,
  parameter int MS_DS_W = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               es_to_ms_valid,
  output logic               ms_allow_in,
  input  logic [ES_MS_W-1:0] es_to_ms_bus,
  input  logic [31:0]        data_sram_rdata,
  input  logic               ws_allow_in,
  output logic               ms_to_ws_valid,
  output logic [MS_WS_W-1:0] ms_to_ws_bus,
  output logic [MS_DS_W-1:0] ms_to_ds_bus,
  input  logic               wb_flush
);

  typedef enum logic [0:0] {
    HOLD_EMPTY = 1'b0,
    HOLD_HELD  = 1'b1
  } hold_state_t;

  logic               ms_valid_r;
  logic [ES_MS_W-1:0] bus_r;
  hold_state_t        hold_state_r;
  hold_state_t        hold_state_s;
  logic [31:0]        hold_data_r;
  logic               capture_s;
  logic               ms_ready_go_s;
  logic               bus_load_s;
  logic [4:0]         load_op_s;
  logic               is_load_s;
  logic [31:0]        alu_result_s;
  logic [31:0]        rdata_eff_s;
  logic [31:0]        final_result_s;
  logic [31:0]        fwd_data_s;
  logic               fwd_we_s;

  // Extract the addressed byte/half and extend it according to the one-hot {hu,bu,w,h,b} op.
  function automatic logic [31:0] align_load(input logic [4:0]  op,
                                             input logic [1:0]  addr,
                                             input logic [31:0] rd);
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res;
    case (addr)
      2'b00:   byte_v = rd[7:0];
      2'b01:   byte_v = rd[15:8];
      2'b10:   byte_v = rd[23:16];
      2'b11:   byte_v = rd[31:24];
      default: byte_v = 8'd0;
    endcase
    if (addr[1]) begin
      half_v = rd[31:16];
    end else begin
      half_v = rd[15:0];
    end
    case (op)
      5'b00001: res = {{24{byte_v[7]}}, byte_v};
      5'b00010: res = {{16{half_v[15]}}, half_v};
      5'b00100: res = rd;
      5'b01000: res = {24'd0, byte_v};
      5'b10000: res = {16'd0, half_v};
      default:  res = 32'd0;
    endcase
    return res;
  endfunction

  assign ms_ready_go_s  = 1'b1;
  assign ms_allow_in    = !ms_valid_r || (ms_ready_go_s && ws_allow_in);
  assign ms_to_ws_valid = ms_valid_r && ms_ready_go_s && !wb_flush;
  assign bus_load_s     = es_to_ms_valid && ms_allow_in && !wb_flush;

  assign load_op_s    = bus_r[171:167];
  assign is_load_s    = |load_op_s;
  assign alu_result_s = bus_r[69:38];

  // Stage valid flag; a flush wins over any incoming instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ms_valid_r <= 1'b0;
    end else if (wb_flush) begin
      ms_valid_r <= 1'b0;
    end else if (ms_allow_in) begin
      ms_valid_r <= es_to_ms_valid;
    end else begin
      ms_valid_r <= ms_valid_r;
    end
  end

  // EX-to-MEM bus register, loaded only for an accepted, unflushed instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_r <= {ES_MS_W{1'b0}};
    end else if (bus_load_s) begin
      bus_r <= es_to_ms_bus;
    end else begin
      bus_r <= bus_r;
    end
  end

  // Hold-buffer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_state_r <= HOLD_EMPTY;
    end else begin
      hold_state_r <= hold_state_s;
    end
  end

  // Hold-buffer next state: SRAM data is only valid for one cycle, so capture it when WB stalls a load.
  always_comb begin
    hold_state_s = hold_state_r;
    capture_s    = 1'b0;
    case (hold_state_r)
      HOLD_EMPTY: begin
        if (ms_valid_r && is_load_s && !ws_allow_in && !wb_flush) begin
          hold_state_s = HOLD_HELD;
          capture_s    = 1'b1;
        end else begin
          hold_state_s = HOLD_EMPTY;
        end
      end
      HOLD_HELD: begin
        if (ws_allow_in || wb_flush || bus_load_s) begin
          hold_state_s = HOLD_EMPTY;
        end else begin
          hold_state_s = HOLD_HELD;
        end
      end
      default: begin
        hold_state_s = HOLD_EMPTY;
      end
    endcase
  end

  // Captured read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data_r <= 32'd0;
    end else if (capture_s) begin
      hold_data_r <= data_sram_rdata;
    end else begin
      hold_data_r <= hold_data_r;
    end
  end

  // Result selection between held/live load data and the ALU result.
  always_comb begin
    rdata_eff_s    = data_sram_rdata;
    final_result_s = alu_result_s;
    if (hold_state_r == HOLD_HELD) begin
      rdata_eff_s = hold_data_r;
    end else begin
      rdata_eff_s = data_sram_rdata;
    end
    if (is_load_s) begin
      final_result_s = align_load(load_op_s, alu_result_s[1:0], rdata_eff_s);
    end else begin
      final_result_s = alu_result_s;
    end
  end

  assign ms_to_ws_bus = {bus_r[166:70], final_result_s, bus_r[37:0]};

`ifdef MS_FWD_EN
  assign fwd_data_s = final_result_s;
  assign fwd_we_s   = ms_valid_r && bus_r[32];
`else
  assign fwd_data_s = 32'd0;
  assign fwd_we_s   = 1'b0;
`endif

  // Stall bits are qualified by ms_valid so a squashed load never stalls ID.
  assign ms_to_ds_bus = {ms_valid_r && (bus_r[118] || bus_r[117]),
                         ms_valid_r && is_load_s,
                         fwd_we_s,
                         bus_r[37:33],
                         fwd_data_s};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed test-plan steps followed by random traffic
// compared against a queue-based model of the instruction sitting in MEM.
module tb_mem_stage;
  localparam int ES_MS_W = 172;
  localparam int MS_WS_W = 167;
  localparam int MS_DS_W = 40;

  logic               clk = 1'b0;
  logic               reset;
  logic               es_to_ms_valid;
  logic               ms_allow_in;
  logic [ES_MS_W-1:0] es_to_ms_bus;
  logic [31:0]        data_sram_rdata;
  logic               ws_allow_in;
  logic               ms_to_ws_valid;
  logic [MS_WS_W-1:0] ms_to_ws_bus;
  logic [MS_DS_W-1:0] ms_to_ds_bus;
  logic               wb_flush;

  mem_stage #(.ES_MS_W(ES_MS_W), .MS_WS_W(MS_WS_W), .MS_DS_W(MS_DS_W)) dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
    .es_to_ms_bus(es_to_ms_bus), .data_sram_rdata(data_sram_rdata), .ws_allow_in(ws_allow_in),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus), .ms_to_ds_bus(ms_to_ds_bus),
    .wb_flush(wb_flush)
  );

  always #5 clk = ~clk;

  // Model: at most one instruction in MEM, with the SRAM word seen in its first cycle there.
  typedef struct {
    logic [171:0] bus;
    logic [31:0]  rdata;
    int           age;
  } inst_t;
  inst_t q[$];

  int n_assert = 0;
  int n_fail   = 0;
  logic [171:0] cur_bus;
  logic cur_ev, cur_wa, cur_fl;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Load result from the architectural rule, using plain arithmetic on the word.
  function automatic logic [31:0] ref_final(input logic [171:0] b, input logic [31:0] rd);
    int unsigned a;
    int unsigned w;
    int unsigned v;
    logic [4:0]  op;
    op = b[171:167];
    a  = {30'd0, b[39:38]};
    w  = rd;
    v  = 0;
    if (op == 5'd0) return b[69:38];
    if (op == 5'b00100) return rd;
    if (op == 5'b00001 || op == 5'b01000) begin
      v = (w >> (8 * a)) % 256;
      if (op == 5'b00001 && v >= 128) v = v + 32'hFFFF_FF00;
    end else begin
      v = (w >> (16 * (a / 2))) % 65536;
      if (op == 5'b00010 && v >= 32768) v = v + 32'hFFFF_0000;
    end
    return v;
  endfunction

  function automatic logic [171:0] mk(input logic [4:0] op, input logic [31:0] alu,
                                      input logic we, input logic [4:0] dest);
    return {op, 15'h1234, 1'b0, 32'hCAFE_0000, 1'b0, 1'b0, 1'b0, 32'h0000_FFFF,
            14'h0010, alu, dest, we, 32'h1C00_0000};
  endfunction

  function automatic logic [39:0] exp_ds(input logic [171:0] b, input logic [31:0] fin);
    logic fwd_we;
    logic [31:0] fwd_d;
`ifdef MS_FWD_EN
    fwd_we = b[32];
    fwd_d  = fin;
`else
    fwd_we = 1'b0;
    fwd_d  = 32'd0;
`endif
    return {b[118] | b[117], b[171:167] != 5'd0, fwd_we, b[37:33], fwd_d};
  endfunction

  task automatic drive_check(input logic ev, input logic [171:0] eb, input logic [31:0] rd,
                             input logic wa, input logic fl);
    logic occ;
    logic [31:0] fin;
    @(negedge clk);
    es_to_ms_valid = ev; es_to_ms_bus = eb; data_sram_rdata = rd;
    ws_allow_in = wa; wb_flush = fl;
    cur_ev = ev; cur_bus = eb; cur_wa = wa; cur_fl = fl;
    #1;
    if (q.size() > 0 && q[0].age == 0) q[0].rdata = rd;
    occ = (q.size() > 0);
    chk("allow_in", 200'(ms_allow_in), 200'(!occ || wa));
    chk("ws_valid", 200'(ms_to_ws_valid), 200'(occ && !fl));
    if (occ) begin
      fin = ref_final(q[0].bus, q[0].rdata);
      if (!fl) chk("ws_bus", 200'(ms_to_ws_bus), 200'({q[0].bus[166:70], fin, q[0].bus[37:0]}));
      chk("ds_bus", 200'(ms_to_ds_bus), 200'(exp_ds(q[0].bus, fin)));
    end else begin
      chk("ds_idle_bits", 200'(ms_to_ds_bus[39:37]), 200'(3'b000));
    end
  endtask

  task automatic tick();
    logic acc;
    @(posedge clk);
    acc = (q.size() == 0 || cur_wa) && cur_ev && !cur_fl;
    if (cur_fl) begin
      q.delete();
    end else begin
      if (q.size() > 0) begin
        if (cur_wa) void'(q.pop_front());
        else q[0].age++;
      end
      if (acc) q.push_back('{cur_bus, 32'd0, 0});
    end
  endtask

  initial begin
    logic [191:0] rnd;
    logic [171:0] rb;
    int r;
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_sram_rdata = 32'd0;
    ws_allow_in = 1'b1; wb_flush = 1'b0;
    cur_ev = 1'b0; cur_bus = '0; cur_wa = 1'b1; cur_fl = 1'b0;
    #2;
    chk("rst_ws_valid", 200'(ms_to_ws_valid), 200'(1'b0));
    chk("rst_ds_bus", 200'(ms_to_ds_bus), 200'(40'd0));
    chk("rst_allow_in", 200'(ms_allow_in), 200'(1'b1));
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // ld.b at 0x1003
    drive_check(1'b1, mk(5'b00001, 32'h0000_1003, 1'b1, 5'd7), 32'h5555_5555, 1'b1, 1'b0); tick();
    drive_check(1'b0, '0, 32'h80FF_1234, 1'b1, 1'b0);
    chk("ldb_valid", 200'(ms_to_ws_valid), 200'(1'b1));
    chk("ldb_result", 200'(ms_to_ws_bus[69:38]), 200'(32'hFFFF_FF80));
    tick();

    // ld.hu upper half
    drive_check(1'b1, mk(5'b10000, 32'h0000_2002, 1'b1, 5'd8), 32'h0, 1'b1, 1'b0); tick();
    drive_check(1'b0, '0, 32'h9ABC_0000, 1'b1, 1'b0);
    chk("ldhu_result", 200'(ms_to_ws_bus[69:38]), 200'(32'h0000_9ABC));
    tick();

    // ld.w stalled by WB for 3 cycles while SRAM data changes
    drive_check(1'b1, mk(5'b00100, 32'h0000_3001, 1'b1, 5'd9), 32'h0, 1'b1, 1'b0); tick();
    drive_check(1'b0, '0, 32'h1122_3344, 1'b0, 1'b0);
    chk("ldw_stall_allow", 200'(ms_allow_in), 200'(1'b0)); tick();
    for (int i = 0; i < 2; i++) begin
      drive_check(1'b1, mk(5'd0, 32'h1, 1'b1, 5'd1), 32'h0000_DEAD, 1'b0, 1'b0);
      chk("ldw_hold_data", 200'(ms_to_ws_bus[69:38]), 200'(32'h1122_3344));
      tick();
    end
    drive_check(1'b0, '0, 32'h0000_DEAD, 1'b1, 1'b0);
    chk("ldw_xfer_valid", 200'(ms_to_ws_valid), 200'(1'b1));
    chk("ldw_xfer_data", 200'(ms_to_ws_bus[69:38]), 200'(32'h1122_3344));
    tick();

    // flush coincident with an incoming instruction
    drive_check(1'b1, mk(5'd0, 32'h77, 1'b1, 5'd3), 32'h0, 1'b1, 1'b1); tick();
    drive_check(1'b0, '0, 32'h0, 1'b1, 1'b0);
    chk("flush_ws_valid", 200'(ms_to_ws_valid), 200'(1'b0));
    chk("flush_allow_in", 200'(ms_allow_in), 200'(1'b1));
    tick();

    // ALU op forwarding
    drive_check(1'b1, mk(5'd0, 32'h42, 1'b1, 5'd5), 32'h0, 1'b1, 1'b0); tick();
    drive_check(1'b0, '0, 32'hFFFF_FFFF, 1'b1, 1'b0);
`ifdef MS_FWD_EN
    chk("alu_fwd", 200'(ms_to_ds_bus), 200'({1'b0, 1'b0, 1'b1, 5'd5, 32'h42}));
`else
    chk("alu_fwd", 200'(ms_to_ds_bus), 200'({1'b0, 1'b0, 1'b0, 5'd5, 32'h0}));
`endif
    tick();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rb = rnd[171:0];
      r = $urandom_range(0, 5);
      rb[171:167] = (r == 0) ? 5'd0 : 5'(1 << (r - 1));
      drive_check($urandom_range(0, 99) < 70, rb, $urandom(),
                  $urandom_range(0, 99) < 65, $urandom_range(0, 99) < 8);
      tick();
    end

    // async reset in the middle of a stall
    drive_check(1'b1, mk(5'b00100, 32'h0000_4000, 1'b1, 5'd6), 32'h0, 1'b1, 1'b0); tick();
    drive_check(1'b0, '0, 32'hAAAA_5555, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mid_rst_ws_valid", 200'(ms_to_ws_valid), 200'(1'b0));
    chk("mid_rst_ds_bus", 200'(ms_to_ds_bus), 200'(40'd0));
    chk("mid_rst_allow_in", 200'(ms_allow_in), 200'(1'b1));
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    cur_ev = 1'b0; cur_fl = 1'b0; cur_wa = 1'b1;
    drive_check(1'b0, '0, 32'h0, 1'b1, 1'b0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
